seq_check_rom: RTL and testbench

//  Receive-side checker for the 3-bit ROM-driven count sequence 0,1,3,5,7,2,0,...
//  (codes 4 and 6 are illegal). It samples a count stream, locks onto the sequence,

---
 rtl/seq_check_pkg.sv | 17 +
 rtl/seq_next_rom.sv | 21 ++
 rtl/seq_check_rom.sv | 125 ++++++++++++
 tb/tb_seq_check_rom.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_check_pkg.sv
// Shared types and constants for the count-sequence checker.
// Sequence: 0,1,3,5,7,2 repeating; codes 4 and 6 never appear.
package seq_check_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'd255;
  localparam int SEQ_LEN = 6;

  // Bit n set when code n is part of the sequence
  localparam logic [7:0] LEGAL_MASK = 8'b1010_1111;

endpackage

// File: rtl/seq_next_rom.sv
// Successor ROM for the count sequence.
// data = {LEGAL, NEXT}; illegal codes return all zeros.
module seq_next_rom (
  input  logic [2:0] addr,
  output logic [3:0] data
);

  always_comb begin
    data = 4'b0_000;
    case (addr)
      3'd0:    data = 4'b1_001;
      3'd1:    data = 4'b1_011;
      3'd3:    data = 4'b1_101;
      3'd5:    data = 4'b1_111;
      3'd7:    data = 4'b1_010;
      3'd2:    data = 4'b1_000;
      default: data = 4'b0_000;
    endcase
  end

endmodule

// File: rtl/seq_check_rom.sv
// Receive-side checker: hunts, syncs and locks onto the count
// sequence, then flags and counts out-of-sequence symbols.
module seq_check_rom
  import seq_check_pkg::*;
#(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [2:0] in_count,
  input  logic       err_clr,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic [2:0] expected
);

  localparam logic [3:0] LOCK_C = 4'(LOCK_N);
  localparam logic [3:0] LOSS_C = 4'(LOSS_N);

  state_t     r_state;
  logic [2:0] r_prev;
  logic [3:0] r_good;
  logic [3:0] r_bad;
  logic [7:0] r_err_cnt;
  logic       r_err;

  state_t     w_state_nx;
  logic [2:0] w_prev_nx;
  logic [3:0] w_good_nx;
  logic [3:0] w_bad_nx;
  logic [7:0] w_cnt_nx;
  logic       w_err_nx;

  logic [3:0] w_rom;
  logic [2:0] w_next;
  logic       w_match;
  logic       w_sym_legal;

  seq_next_rom u_rom (
    .addr (r_prev),
    .data (w_rom)
  );

  assign w_next      = w_rom[2:0];
  assign w_match     = w_rom[3] && (in_count == w_next);
  assign w_sym_legal = LEGAL_MASK[in_count];

  always_comb begin
    w_state_nx = r_state;
    w_prev_nx  = r_prev;
    w_good_nx  = r_good;
    w_bad_nx   = r_bad;
    w_cnt_nx   = r_err_cnt;
    w_err_nx   = 1'b0;
    if (in_valid) begin
      unique case (r_state)
        HUNT: begin
          if (w_sym_legal) begin
            w_prev_nx  = in_count;
            w_good_nx  = 4'd0;
            w_state_nx = SYNC;
          end
        end
        SYNC: begin
          if (w_match) begin
            w_prev_nx = in_count;
            w_good_nx = r_good + 4'd1;
            if (r_good + 4'd1 == LOCK_C) begin
              w_state_nx = LOCKED;
              w_bad_nx   = 4'd0;
            end
          end else begin
            w_state_nx = HUNT;
            w_good_nx  = 4'd0;
          end
        end
        LOCKED: begin
          if (w_match) begin
            w_prev_nx = in_count;
            w_bad_nx  = 4'd0;
          end else begin
            // Flywheel: advance on our own prediction
            w_err_nx  = 1'b1;
            w_prev_nx = w_next;
            w_bad_nx  = r_bad + 4'd1;
            if (r_err_cnt != CNT_MAX)
              w_cnt_nx = r_err_cnt + 8'd1;
            if (r_bad + 4'd1 == LOSS_C)
              w_state_nx = HUNT;
          end
        end
        default: w_state_nx = HUNT;
      endcase
    end
    if (err_clr)
      w_cnt_nx = 8'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= HUNT;
      r_prev    <= 3'd0;
      r_good    <= 4'd0;
      r_bad     <= 4'd0;
      r_err_cnt <= 8'd0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_prev    <= w_prev_nx;
      r_good    <= w_good_nx;
      r_bad     <= w_bad_nx;
      r_err_cnt <= w_cnt_nx;
      r_err     <= w_err_nx;
    end
  end

  assign locked   = (r_state == LOCKED);
  assign err      = r_err;
  assign err_cnt  = r_err_cnt;
  assign expected = (r_state == HUNT) ? 3'd0 : w_next;

endmodule

// File: tb/tb_seq_check_rom.sv
// Bench for seq_check_rom: directed table, multi-cycle
// corner sequences and randomized traffic against a reference model.
module tb_seq_check_rom;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [2:0] in_count;
  logic       err_clr;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [2:0] expected;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_check_rom #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_count (in_count),
    .err_clr  (err_clr),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .expected (expected)
  );

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic       clr;
    logic       lk;
    logic       er;
    logic [7:0] cnt;
    logic [2:0] ex;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input int c, input logic clr,
                              input logic lk, input logic er,
                              input int cnt, input int ex);
    vec_t r;
    r.v = v; r.c = 3'(c); r.clr = clr;
    r.lk = lk; r.er = er; r.cnt = 8'(cnt); r.ex = 3'(ex);
    return r;
  endfunction

  task automatic check(input string name, input logic lk, input logic er,
                       input logic [7:0] cnt, input logic [2:0] ex);
    n_run++;
    if ({locked, err, err_cnt, expected} !== {lk, er, cnt, ex}) begin
      n_fail++;
      $display("FAIL %s: got locked=%0b err=%0b err_cnt=%0d expected=%0d, want locked=%0b err=%0b err_cnt=%0d expected=%0d",
               name, locked, err, err_cnt, expected, lk, er, cnt, ex);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic clr);
    @(negedge clk);
    in_valid = v; in_count = c; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // Reference model: successor table plus run counters
  int  succ[8];
  int  m_prev, m_ok, m_miss, m_cnt;
  bit  m_hunting, m_lock, m_err;

  task automatic model_reset();
    m_hunting = 1; m_lock = 0; m_err = 0;
    m_prev = 0; m_ok = 0; m_miss = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit v, input int c, input bit clr);
    m_err = 0;
    if (v) begin
      if (m_hunting) begin
        if (c != 4 && c != 6) begin
          m_hunting = 0; m_prev = c; m_ok = 0;
        end
      end else if (!m_lock) begin
        if (c == succ[m_prev]) begin
          m_prev = c; m_ok++;
          if (m_ok >= LOCK_N) begin m_lock = 1; m_miss = 0; end
        end else begin
          m_hunting = 1; m_ok = 0;
        end
      end else if (c == succ[m_prev]) begin
        m_prev = c; m_miss = 0;
      end else begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
        m_miss++;
        m_prev = succ[m_prev];
        if (m_miss >= LOSS_N) begin m_lock = 0; m_hunting = 1; end
      end
    end
    if (clr) m_cnt = 0;
  endtask

  task automatic step(input string name, input bit v, input int c, input bit clr);
    int ex;
    drive(v, 3'(c), clr);
    model_step(v, c, clr);
    ex = m_hunting ? 0 : succ[m_prev];
    check(name, m_lock, m_err, 8'(m_cnt), 3'(ex));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int lockseq[5];
    lockseq = '{0, 1, 3, 5, 7};
    succ = '{1, 3, 0, 5, 0, 7, 0, 2};

    reset_n = 1'b0; in_valid = 1'b0; in_count = 3'd0; err_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; in_count = 3'(i + 1);
      @(posedge clk);
      #1;
      check("reset_hold", 1'b0, 1'b0, 8'd0, 3'd0);
    end
    @(negedge clk);
    reset_n = 1'b1; in_valid = 1'b0;

    // lock
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 5));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 7));
    tbl.push_back(mk(1, 7, 0, 1, 0, 0, 2));
    // single error with flywheel
    tbl.push_back(mk(1, 2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 6, 0, 1, 1, 1, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, 1, 3));
    tbl.push_back(mk(1, 3, 1, 1, 0, 0, 5));
    // loss of lock
    tbl.push_back(mk(1, 4, 0, 1, 1, 1, 7));
    tbl.push_back(mk(1, 4, 0, 1, 1, 2, 2));
    tbl.push_back(mk(1, 4, 0, 0, 1, 3, 0));
    // illegal codes keep HUNT
    tbl.push_back(mk(1, 6, 0, 0, 0, 3, 0));
    tbl.push_back(mk(1, 4, 0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 5, 0, 0, 0, 3, 0));
    // lock with gaps, then clear against an error
    tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1));
    tbl.push_back(mk(0, 3, 0, 0, 0, 3, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 3, 3));
    tbl.push_back(mk(0, 7, 0, 0, 0, 3, 3));
    tbl.push_back(mk(1, 3, 0, 0, 0, 3, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 5));
    tbl.push_back(mk(1, 5, 0, 0, 0, 3, 7));
    tbl.push_back(mk(0, 2, 0, 0, 0, 3, 7));
    tbl.push_back(mk(1, 7, 0, 1, 0, 3, 2));
    tbl.push_back(mk(0, 4, 0, 1, 0, 3, 2));
    tbl.push_back(mk(1, 4, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].clr);
      check($sformatf("tbl[%0d]", i), tbl[i].lk, tbl[i].er,
            tbl[i].cnt, tbl[i].ex);
    end

    // saturation: 100 relock/lose rounds = 300 errors
    do_reset();
    for (int k = 0; k < 100; k++) begin
      for (int s = 0; s < 5; s++) step("sat_lock", 1, lockseq[s], 0);
      for (int e = 0; e < 3; e++) step("sat_err", 1, 4, 0);
    end
    n_run++;
    if (err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_255: got err_cnt=%0d want 255", err_cnt);
    end

    // async reset mid-burst
    for (int s = 0; s < 5; s++) step("burst_lock", 1, lockseq[s], 0);
    step("burst_err", 1, 4, 0);
    @(negedge clk);
    in_valid = 1'b1; in_count = 3'd6;
    #2 reset_n = 1'b0;
    #1 check("async_rst", 1'b0, 1'b0, 8'd0, 3'd0);
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit v, clr;
      int c;
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      if (!m_hunting && $urandom_range(0, 9) < 8) c = succ[m_prev];
      else c = int'($urandom_range(0, 7));
      step("rand", v, c, clr);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
